// File: rtl/spi_pkg.sv
// Shared SPI types: FSM states, default geometry, SCLK edge strobes.
// Used by spi_master and spi_clk_gen.
package spi_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_DIV    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } sclkEdge_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period counter, SCLK level and edge strobes.
// The strobe marks the clock edge on which SCLK is about to toggle.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  logic      hold,
  output logic      SCLK,
  output logic      tick,
  output sclkEdge_t edgeStb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Strobe decode; hold lets the counter time HOLD without toggling SCLK
  always_comb begin
    edgeStb = EDGE_NONE;
    if (tick && !hold)
      edgeStb = SCLK ? EDGE_FALL : EDGE_RISE;
  end

  // Half-period counter and SCLK level register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      SCLK <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      SCLK <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      if (!hold)
        SCLK <= ~SCLK;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master, LSB first, CS active low, one byte per start.
// Define SPI_MASTER_LOOPBACK_EN to feed MOSI back into the RX shifter.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] masterDataToSend,
  output logic [DATA_WIDTH-1:0] masterDataReceived,
  output logic                  busy,
  output logic                  done,
  output logic                  SCLK,
  output logic                  CS,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] txReg;
  logic [DATA_WIDTH-1:0] rxReg;
  logic [BW-1:0]         bitCnt;
  logic                  tick;
  logic                  inHold;
  logic                  rxIn;
  sclkEdge_t             edgeStb;

  assign inHold = (state == HOLD);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rxIn = MOSI;
`else
  assign rxIn = MISO;
`endif

  // Counter runs from the registered busy flag, so the first
  // rise lands H clocks after CS falls.
  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) uClkGen (
    .clk    (clk),
    .reset  (reset),
    .en     (busy),
    .hold   (inHold),
    .SCLK   (SCLK),
    .tick   (tick),
    .edgeStb(edgeStb)
  );

  // FSM, shifters, bit counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= IDLE;
      txReg              <= '0;
      rxReg              <= '0;
      bitCnt             <= '0;
      MOSI               <= 1'b0;
      CS                 <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      masterDataReceived <= '0;
    end else begin
      done <= 1'b0;
      if (edgeStb == EDGE_RISE) begin
        MOSI  <= txReg[0];
        txReg <= txReg >> 1;
      end
      if (edgeStb == EDGE_FALL) begin
        rxReg  <= {rxIn, rxReg[DATA_WIDTH-1:1]};
        bitCnt <= bitCnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= SETUP;
            txReg  <= masterDataToSend;
            bitCnt <= '0;
          end
        end
        SETUP: begin
          CS   <= 1'b0;
          busy <= 1'b1;
          if (edgeStb == EDGE_RISE)
            state <= SHIFT;
        end
        SHIFT: begin
          if (edgeStb == EDGE_FALL && bitCnt == LAST_BIT)
            state <= HOLD;
        end
        HOLD: begin
          if (tick) begin
            masterDataReceived <= rxReg;
            done               <= 1'b1;
            CS                 <= 1'b1;
            busy               <= 1'b0;
            if (start) begin
              state  <= SETUP;
              txReg  <= masterDataToSend;
              bitCnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: CLK_DIV=3 and CLK_DIV=1 instances.
// Honours SPI_MASTER_LOOPBACK_EN for the expected RX bytes.
module tb_spi_master;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          startA, busyA, doneA, SCLKA, CSA, MOSIA, MISOA;
  logic [DW-1:0] txA, rxA;
  logic          startB, busyB, doneB, SCLKB, CSB, MOSIB, MISOB;
  logic [DW-1:0] txB, rxB;

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(3)) dutA (
    .clk(clk), .reset(reset), .start(startA),
    .masterDataToSend(txA), .masterDataReceived(rxA),
    .busy(busyA), .done(doneA), .SCLK(SCLKA),
    .CS(CSA), .MOSI(MOSIA), .MISO(MISOA)
  );

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(1)) dutB (
    .clk(clk), .reset(reset), .start(startB),
    .masterDataToSend(txB), .masterDataReceived(rxB),
    .busy(busyB), .done(doneB), .SCLK(SCLKB),
    .CS(CSB), .MOSI(MOSIB), .MISO(MISOB)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] rxQA[$], slvQA[$], rxQB[$], slvQB[$];
  logic          bitQA[$], bitQB[$];
  int            doneCntA = 0, doneCntB = 0;

  function automatic logic [DW-1:0] expRx(input logic [DW-1:0] tx,
                                          input logic [DW-1:0] slv);
`ifdef SPI_MASTER_LOOPBACK_EN
    return tx;
`else
    return slv;
`endif
  endfunction

  task automatic pushA(input logic [DW-1:0] tx, input logic [DW-1:0] slv);
    for (int i = 0; i < DW; i++) bitQA.push_back(tx[i]);
    slvQA.push_back(slv);
    rxQA.push_back(expRx(tx, slv));
  endtask

  task automatic pushB(input logic [DW-1:0] tx, input logic [DW-1:0] slv);
    for (int i = 0; i < DW; i++) bitQB.push_back(tx[i]);
    slvQB.push_back(slv);
    rxQB.push_back(expRx(tx, slv));
  endtask

  // Slave models: load byte on CS fall, present next bit after each rise
  logic [DW-1:0] slvA = '0, slvB = '0;
  int            idxA = 0, idxB = 0;
  initial begin MISOA = 1'b0; MISOB = 1'b0; end

  always @(negedge CSA) begin
    slvA = (slvQA.size() != 0) ? slvQA.pop_front() : '0;
    idxA = 0;
  end
  always @(posedge SCLKA) begin
    MISOA = (idxA < DW) ? slvA[idxA] : 1'b0;
    idxA++;
  end
  always @(negedge CSB) begin
    slvB = (slvQB.size() != 0) ? slvQB.pop_front() : '0;
    idxB = 0;
  end
  always @(posedge SCLKB) begin
    MISOB = (idxB < DW) ? slvB[idxB] : 1'b0;
    idxB++;
  end

  // MOSI is stable through the high phase; check it on the fall
  always @(negedge SCLKA) if (reset === 1'b1) begin
    check("mosiA_q", bitQA.size() != 0, 1);
    if (bitQA.size() != 0) check("mosiA", MOSIA, bitQA.pop_front());
  end
  always @(negedge SCLKB) if (reset === 1'b1) begin
    check("mosiB_q", bitQB.size() != 0, 1);
    if (bitQB.size() != 0) check("mosiB", MOSIB, bitQB.pop_front());
  end

  always @(negedge clk) begin
    if (doneA === 1'b1) begin
      doneCntA++;
      check("doneA_q", rxQA.size() != 0, 1);
      if (rxQA.size() != 0) check("rxA", rxA, rxQA.pop_front());
    end
    if (doneB === 1'b1) begin
      doneCntB++;
      check("doneB_q", rxQB.size() != 0, 1);
      if (rxQB.size() != 0) check("rxB", rxB, rxQB.pop_front());
    end
  end

  task automatic kickA(input logic [DW-1:0] tx, input logic [DW-1:0] slv);
    @(negedge clk);
    startA = 1'b1;
    txA    = tx;
    pushA(tx, slv);
    @(posedge clk);
  endtask

  // Walk edges after acceptance (edge 0) until CS rises
  task automatic runA(input int startN, input bit holdStart,
                      input int pulseAt, input int resetAt, input int chgAt,
                      input logic [DW-1:0] chgTx, input logic [DW-1:0] chgSlv,
                      output int csRise, output int firstRise);
    csRise    = 0;
    firstRise = 0;
    for (int n = startN; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        check("csFall", CSA, 0);
        check("busyRise", busyA, 1);
        if (!holdStart) startA = 1'b0;
      end
      if (SCLKA && firstRise == 0) firstRise = n;
      if (n == chgAt) begin
        txA = chgTx;
        pushA(chgTx, chgSlv);
      end
      if (n == pulseAt - 1) begin
        startA = 1'b1;
        txA    = 8'hA5;
      end
      if (n == pulseAt) startA = 1'b0;
      if (n == resetAt - 1) reset = 1'b0;
      if (n == resetAt) begin
        check("rstCs", CSA, 1);
        check("rstSclk", SCLKA, 0);
        check("rstBusy", busyA, 0);
        check("rstRx", rxA, 0);
        check("rstDone", doneA, 0);
        reset = 1'b1;
        return;
      end
      if (CSA) begin
        csRise = n;
        return;
      end
    end
    check("timeoutA", 0, 1);
  endtask

  int csR, fR, dc;

  initial begin
    reset  = 1'b0;
    startA = 1'b0; txA = '0;
    startB = 1'b0; txB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rstA_cs", CSA, 1);
    check("rstA_sclk", SCLKA, 0);
    check("rstA_mosi", MOSIA, 0);
    check("rstA_busy", busyA, 0);
    check("rstA_done", doneA, 0);
    check("rstA_rx", rxA, 0);
    check("rstB_cs", CSB, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic transfer
    dc = doneCntA;
    kickA(8'b01010011, 8'b00001001);
    runA(1, 0, -1, -1, -1, '0, '0, csR, fR);
    check("basic_rise0", fR, 4);
    check("basic_csRise", csR, 52);
    check("basic_done", doneA, 1);
    @(posedge clk); #1;
    check("basic_donePulse", doneA, 0);
    check("basic_doneCnt", doneCntA - dc, 1);

    // Back-to-back with start held
    repeat (3) @(negedge clk);
    dc = doneCntA;
    kickA(8'b00111100, 8'b10011000);
    runA(1, 1, -1, -1, 10, 8'b01011111, 8'b11111111, csR, fR);
    check("b2b_csRise1", csR, 52);
    @(posedge clk); #1;
    check("b2b_gap", CSA, 0);
    startA = 1'b0;
    runA(2, 0, -1, -1, -1, '0, '0, csR, fR);
    check("b2b_rise0", fR, 4);
    check("b2b_csRise2", csR, 52);
    @(posedge clk); #1;
    check("b2b_doneCnt", doneCntA - dc, 2);

    // Start pulse while busy is ignored
    repeat (3) @(negedge clk);
    dc = doneCntA;
    kickA(8'b11000110, 8'b01100101);
    runA(1, 0, 20, -1, -1, '0, '0, csR, fR);
    check("ign_csRise", csR, 52);
    repeat (10) @(posedge clk);
    #1;
    check("ign_noRestartCs", CSA, 1);
    check("ign_noRestartBusy", busyA, 0);
    check("ign_doneCnt", doneCntA - dc, 1);

    // Mid-transfer reset
    repeat (3) @(negedge clk);
    dc = doneCntA;
    kickA(8'b11110000, 8'b10101010);
    runA(1, 0, -1, 30, -1, '0, '0, csR, fR);
    bitQA.delete();
    rxQA.delete();
    slvQA.delete();
    repeat (60) @(posedge clk);
    #1;
    check("rst_noDone", doneCntA - dc, 0);
    check("rst_rxKept", rxA, 0);
    check("rst_idleCs", CSA, 1);

    // Loopback pattern with MISO at 0
    repeat (3) @(negedge clk);
    kickA(8'b10011000, 8'b00000000);
    runA(1, 0, -1, -1, -1, '0, '0, csR, fR);
    check("lb_csRise", csR, 52);

    // CLK_DIV=1 instance
    repeat (3) @(negedge clk);
    dc = doneCntB;
    startB = 1'b1;
    txB    = 8'b01010101;
    pushB(8'b01010101, 8'b11111111);
    @(posedge clk); #1;
    startB = 1'b0;
    csR = 0;
    fR  = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) check("div1_csFall", CSB, 0);
      if (SCLKB && fR == 0) fR = n;
      if (CSB) begin
        csR = n;
        break;
      end
    end
    check("div1_rise0", fR, 2);
    check("div1_csRise", csR, 18);
    @(posedge clk); #1;
    check("div1_doneCnt", doneCntB - dc, 1);

    repeat (5) @(posedge clk);
    check("leftA_rx", rxQA.size(), 0);
    check("leftA_bits", bitQA.size(), 0);
    check("leftB_rx", rxQB.size(), 0);
    check("leftB_bits", bitQB.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
